// File: rtl/mm2s_pkg.sv
// Shared types, constants and helpers for the MM2S read master.
// Holds the stream-out FSM states and the byte-count/keep helpers.
package mm2s_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } so_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_MAX_BEATS  = 256;

    // Beats for a byte length. Shift-and-round-up form, so
    // lengths near 2^32 cannot wrap the way len+BPB-1 would.
    function automatic logic [31:0] ceil_beats(
        input logic [31:0] len,
        input int          bpb
    );
        logic [31:0] mask;
        int          sh;
        mask = 32'(bpb - 1);
        sh   = $clog2(bpb);
        return (len >> sh) + {31'd0, |(len & mask)};
    endfunction

    // Byte enables of the final beat, LSB-aligned.
    // Returned 64 bits wide; callers truncate to BPB.
    function automatic logic [63:0] last_keep(
        input logic [31:0] len,
        input int          bpb
    );
        logic [63:0] ones;
        logic [63:0] rem;
        ones = (bpb >= 64) ? '1 : ((64'd1 << bpb) - 64'd1);
        rem  = {32'd0, len} & (64'(bpb) - 64'd1);
        return (rem == 64'd0) ? ones : ((64'd1 << rem) - 64'd1);
    endfunction

endpackage

// File: rtl/mm2s_out_buf2.sv
// Two-entry in-order output buffer for the stream-out stage.
// Ports: clk, rst_n (sync, low), flush, push/push_data, pop,
//        head (oldest entry), occ (0..2 entries held).
module mm2s_out_buf2 #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    occ
);

    logic [DW-1:0] e0;
    logic [DW-1:0] e1;

    assign head = e0;

    // pop is only raised when occ != 0 and push only when a slot
    // is free after this cycle's pop, so no full/empty guards.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= push_data;
                    else             e1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        e0 <= push_data;
                    end else begin
                        e0 <= e1;
                        e1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mm2s_axis_stream_out.sv
// MM2S stream-out stage: pops the data FIFO, emits AXI4-Stream.
// Ports: start_i/len_bytes_i/abort_i/busy_o/done_o command side,
//        fifo_empty/fifo_rd_en/fifo_rd_data, m_axis_* stream.
module mm2s_axis_stream_out
    import mm2s_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [31:0]     len_bytes_i,
    input  logic            abort_i,
    output logic            busy_o,
    output logic            done_o,
    input  logic            fifo_empty,
    output logic            fifo_rd_en,
    input  logic [DW-1:0]   fifo_rd_data,
    output logic [DW-1:0]   m_axis_tdata,
    output logic [DW/8-1:0] m_axis_tkeep,
    output logic            m_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready
);

    localparam int BPB = DW / 8;

    so_state_t       state;
    logic [31:0]     rd_left;
    logic [31:0]     tx_left;
    logic [BPB-1:0]  keep_last_q;
    logic            inflight;
    logic            done_q;

    logic [31:0]     beats;
    logic [BPB-1:0]  keep_new;
    logic [1:0]      occ;
    logic [DW-1:0]   head;
    logic            tvalid;
    logic            tlast;
    logic            fire;
    logic            run;
    logic            kill;
    logic [2:0]      credit;

    assign beats    = ceil_beats(len_bytes_i, BPB);
    assign keep_new = BPB'(last_keep(len_bytes_i, BPB));

    assign run    = (state == S_RUN);
    assign kill   = run && abort_i;
    assign tvalid = (occ != 2'd0);
    assign fire   = tvalid && m_axis_tready;
    assign tlast  = tvalid && (tx_left == 32'd1);

    // Entries that will be held after this cycle if nothing new
    // is popped; fire implies occ >= 1 so this never underflows.
    assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, fire};

    assign fifo_rd_en = run && !fifo_empty &&
                        (rd_left != 32'd0) && (credit < 3'd2);

    mm2s_out_buf2 #(
        .DW (DW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (kill),
        .push      (inflight && run),
        .push_data (fifo_rd_data),
        .pop       (fire),
        .head      (head),
        .occ       (occ)
    );

    assign m_axis_tvalid = tvalid;
    assign m_axis_tdata  = head;
    assign m_axis_tlast  = tlast;
    assign m_axis_tkeep  = !tvalid ? '0 :
                           (tlast ? keep_last_q : '1);

    assign busy_o = (state != S_IDLE);
    assign done_o = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rd_left     <= 32'd0;
            tx_left     <= 32'd0;
            keep_last_q <= '0;
            inflight    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= fifo_rd_en;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_bytes_i == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            rd_left     <= beats;
                            tx_left     <= beats;
                            keep_last_q <= keep_new;
                            state       <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        // Drop the returning read and all counts.
                        state    <= S_IDLE;
                        rd_left  <= 32'd0;
                        tx_left  <= 32'd0;
                        inflight <= 1'b0;
                    end else begin
                        if (fifo_rd_en) rd_left <= rd_left - 32'd1;
                        if (fire)       tx_left <= tx_left - 32'd1;
                        if (fire && tlast) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm2s_axis_stream_out.sv
// Directed bench for mm2s_axis_stream_out (DW=64) with a FIFO
// model and a stream scoreboard sampled on the falling edge.
module tb_mm2s_axis_stream_out;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [31:0]   len_bytes_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic [DW-1:0] m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;

    always #5 clk = ~clk;

    mm2s_axis_stream_out #(.DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .len_bytes_i   (len_bytes_i),
        .abort_i       (abort_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    // FIFO model: registered read, one-cycle latency
    logic [DW-1:0] mem [0:1023];
    logic [9:0]    wp = '0;
    logic [9:0]    rp = '0;
    logic          gap = 1'b0;
    logic          flush_req = 1'b0;

    assign fifo_empty = (rp == wp) || gap;

    always @(posedge clk) begin
        if (flush_req) begin
            rp <= wp;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rp];
            rp <= rp + 10'd1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Scoreboard state
    int         cyc = 0;
    int         n_done = 0;
    int         n_valid = 0;
    int         start_cyc = -1;
    int         done_cyc = -1;
    int         first_fire_cyc = -1;
    int         last_fire_cyc = -1;
    int         bi = 0;
    int         beats = 0;
    int         pops = 0;
    int         fires = 0;
    logic [7:0] klast = '0;
    logic [9:0] ex_idx = '0;
    logic [9:0] rp0 = '0;
    logic       mon_rand = 1'b0;
    logic       pv_hold = 1'b0;
    logic [63:0] pv_data = '0;
    logic [7:0] pv_keep = '0;
    logic       pv_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (start_i) start_cyc = cyc;
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (m_axis_tvalid) n_valid++;
        if (fifo_rd_en) pops++;
        if (pv_hold) begin
            chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
            chk("hold_data", m_axis_tdata, pv_data);
            chk("hold_keep", 64'(m_axis_tkeep), 64'(pv_keep));
            chk("hold_last", 64'(m_axis_tlast), 64'(pv_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (bi == 0) first_fire_cyc = cyc;
            last_fire_cyc = cyc;
            chk("beat_data", m_axis_tdata, mem[ex_idx]);
            chk("beat_last", 64'(m_axis_tlast), 64'(bi == beats - 1));
            chk("beat_keep", 64'(m_axis_tkeep),
                (bi == beats - 1) ? 64'(klast) : 64'hFF);
            ex_idx++;
            bi++;
            fires++;
        end
        if (mon_rand) chk("occ_le2", 64'(pops - fires <= 2), 64'd1);
        pv_hold = m_axis_tvalid && !m_axis_tready && !abort_i && rst_n;
        pv_data = m_axis_tdata;
        pv_keep = m_axis_tkeep;
        pv_last = m_axis_tlast;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wp] = {16'hC0DE, 6'd0, wp, $urandom()};
            wp = wp + 10'd1;
        end
    endtask

    task automatic flush_fifo();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        ex_idx = wp;
    endtask

    task automatic start_cmd(input logic [31:0] len, input int nb,
                             input logic [7:0] kl);
        beats = nb;
        klast = kl;
        bi = 0;
        pops = 0;
        fires = 0;
        rp0 = rp;
        start_i = 1'b1;
        len_bytes_i = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0;
        n0 = n_done;
        for (int i = 0; i < budget; i++) begin
            if (n_done != n0) break;
            tick();
        end
        chk(tag, 64'(n_done != n0), 64'd1);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
        chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
        chk({tag, "_tdata"}, m_axis_tdata, 64'd0);
        chk({tag, "_tkeep"}, 64'(m_axis_tkeep), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int nd0;
    int nv0;

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        len_bytes_i = '0;
        abort_i = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk_idle_outs("rst");
        rst_n = 1'b1;
        tick();

        // 64 bytes: 8 full beats back to back
        push_words(8);
        nd0 = n_done;
        start_cmd(32'd64, 8, 8'hFF);
        wait_done("l64_done", 100);
        repeat (4) tick();
        chk("l64_beats", 64'(bi), 64'd8);
        chk("l64_consec", 64'(last_fire_cyc - first_fire_cyc), 64'd7);
        chk("l64_done_t", 64'(done_cyc - last_fire_cyc), 64'd2);
        chk("l64_ndone", 64'(n_done - nd0), 64'd1);
        chk("l64_pops", 64'(rp - rp0), 64'd8);

        // 20 bytes: 3 beats, partial keep, no overfetch
        push_words(5);
        start_cmd(32'd20, 3, 8'h0F);
        wait_done("l20_done", 100);
        repeat (3) tick();
        chk("l20_beats", 64'(bi), 64'd3);
        chk("l20_pops", 64'(rp - rp0), 64'd3);
        flush_fifo();

        // zero length
        push_words(2);
        nd0 = n_done;
        nv0 = n_valid;
        start_cmd(32'd0, 0, 8'h00);
        wait_done("l0_done", 20);
        repeat (3) tick();
        chk("l0_done_t", 64'(done_cyc - start_cyc), 64'd2);
        chk("l0_ndone", 64'(n_done - nd0), 64'd1);
        chk("l0_tvalid", 64'(n_valid - nv0), 64'd0);
        chk("l0_pops", 64'(rp - rp0), 64'd0);
        flush_fifo();

        // 256 bytes with random back-pressure and FIFO gaps
        push_words(32);
        nd0 = n_done;
        mon_rand = 1'b1;
        start_cmd(32'd256, 32, 8'hFF);
        for (int i = 0; i < 3000 && n_done == nd0; i++) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            gap = ($urandom_range(0, 2) == 0);
            tick();
        end
        m_axis_tready = 1'b1;
        gap = 1'b0;
        mon_rand = 1'b0;
        chk("rnd_done", 64'(n_done - nd0), 64'd1);
        chk("rnd_beats", 64'(bi), 64'd32);
        chk("rnd_pops", 64'(rp - rp0), 64'd32);
        repeat (2) tick();

        // abort after beat 3 of 16 with a read in flight
        push_words(16);
        nd0 = n_done;
        start_cmd(32'd128, 16, 8'hFF);
        for (int i = 0; i < 50; i++) begin
            if (bi >= 3) break;
            tick();
        end
        chk("ab_beats", 64'(bi), 64'd3);
        m_axis_tready = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("ab_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("ab_busy", 64'(busy_o), 64'd0);
        repeat (5) tick();
        chk("ab_nodone", 64'(n_done - nd0), 64'd0);
        chk("ab_pops", 64'(rp - rp0), 64'd5);
        ex_idx = rp0 + 10'd5;
        start_cmd(32'd64, 8, 8'hFF);
        wait_done("ab_next_done", 100);
        repeat (3) tick();
        chk("ab_next_beats", 64'(bi), 64'd8);
        chk("ab_next_pops", 64'(rp - rp0), 64'd8);
        flush_fifo();

        // start while busy is ignored
        push_words(4);
        nd0 = n_done;
        start_cmd(32'd32, 4, 8'hFF);
        start_i = 1'b1;
        len_bytes_i = 32'd800;
        chk("sb_busy", 64'(busy_o), 64'd1);
        tick();
        start_i = 1'b0;
        wait_done("sb_done", 100);
        repeat (4) tick();
        chk("sb_beats", 64'(bi), 64'd4);
        chk("sb_pops", 64'(rp - rp0), 64'd4);
        chk("sb_idle", 64'(busy_o), 64'd0);
        chk("sb_ndone", 64'(n_done - nd0), 64'd1);

        // synchronous reset mid-burst
        push_words(8);
        nd0 = n_done;
        start_cmd(32'd64, 8, 8'hFF);
        for (int i = 0; i < 50; i++) begin
            if (bi >= 2) break;
            tick();
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk_idle_outs("mrst");
        rst_n = 1'b1;
        flush_fifo();
        repeat (3) tick();
        chk("mrst_nodone", 64'(n_done - nd0), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
